dmem_access_sched: RTL and testbench

//  Two-port arbiter/sequencer in front of the 4-lane data memory block (16-bit address, 4x16-bit

---
 rtl/dmem_pkg.sv | 17 +
 rtl/rr_arb2.sv | 20 ++
 rtl/dmem_access_sched.sv | 162 ++++++++++++++++
 tb/tb_dmem_access_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory access scheduler
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_LD = 1'b0,
    GNT_CP = 1'b1
  } grant_e;

  localparam int ACCESS_CYCLES_DEF = 6;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, onehot grant (bit0 loader, bit1 compute)
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] i_req,
  input  grant_e     i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == GNT_CP) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_access_sched.sv
// rtl/dmem_access_sched.sv - shares the 4-lane data memory between loader writes and compute reads,
// holding each access for a fixed sequencing time before acknowledging the requester.
module dmem_access_sched
  import dmem_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data1,
  input  logic [DATA_W-1:0] ld_data2,
  input  logic [DATA_W-1:0] ld_data3,
  input  logic [DATA_W-1:0] ld_data4,
  output logic              ld_ack,
  input  logic              cp_req,
  input  logic [ADDR_W-1:0] cp_addr,
  output logic              cp_valid,
  output logic [DATA_W-1:0] cp_q1,
  output logic [DATA_W-1:0] cp_q2,
  output logic [DATA_W-1:0] cp_q3,
  output logic [DATA_W-1:0] cp_q4,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_data1,
  output logic [DATA_W-1:0] mem_data2,
  output logic [DATA_W-1:0] mem_data3,
  output logic [DATA_W-1:0] mem_data4,
  input  logic [DATA_W-1:0] mem_q1,
  input  logic [DATA_W-1:0] mem_q2,
  input  logic [DATA_W-1:0] mem_q3,
  input  logic [DATA_W-1:0] mem_q4,
  output logic              busy
);

  localparam int             CNT_W    = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  grant_e            r_last_grant;
  grant_e            r_cur_grant;
  logic [1:0]        r_ack_seen;
  logic [1:0]        w_req_masked;
  logic [1:0]        w_grant;

  logic              r_ld_ack;
  logic              r_cp_valid;
  logic              r_busy;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_d1, r_mem_d2, r_mem_d3, r_mem_d4;
  logic [DATA_W-1:0] r_cp_q1, r_cp_q2, r_cp_q3, r_cp_q4;

  // A port acked last cycle may still hold its request; hide it for one IDLE cycle.
  assign w_req_masked = {cp_req & ~r_ack_seen[1], ld_req & ~r_ack_seen[0]};

  rr_arb2 u_arb (
    .i_req        (w_req_masked),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_grant) w_state_nxt = ACCESS;
      ACCESS:  if (r_cnt == CNT_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= GNT_CP;
      r_cur_grant  <= GNT_LD;
      r_ack_seen   <= 2'b00;
      r_ld_ack     <= 1'b0;
      r_cp_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_d1     <= '0;
      r_mem_d2     <= '0;
      r_mem_d3     <= '0;
      r_mem_d4     <= '0;
      r_cp_q1      <= '0;
      r_cp_q2      <= '0;
      r_cp_q3      <= '0;
      r_cp_q4      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_ack   <= 1'b0;
      r_cp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ack_seen <= 2'b00;
          if (w_grant[0]) begin
            r_mem_addr  <= ld_addr;
            r_mem_d1    <= ld_data1;
            r_mem_d2    <= ld_data2;
            r_mem_d3    <= ld_data3;
            r_mem_d4    <= ld_data4;
            r_mem_we    <= 1'b1;
            r_cur_grant <= GNT_LD;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
          end else if (w_grant[1]) begin
            r_mem_addr  <= cp_addr;
            r_mem_we    <= 1'b0;
            r_cur_grant <= GNT_CP;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
          end
        end
        ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            r_mem_we <= 1'b0;
            r_busy   <= 1'b0;
            if (r_cur_grant == GNT_CP) begin
              r_cp_q1 <= mem_q1;
              r_cp_q2 <= mem_q2;
              r_cp_q3 <= mem_q3;
              r_cp_q4 <= mem_q4;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (r_cur_grant == GNT_LD) r_ld_ack   <= 1'b1;
          else                       r_cp_valid <= 1'b1;
          r_last_grant <= r_cur_grant;
          r_ack_seen   <= {r_cur_grant == GNT_CP, r_cur_grant == GNT_LD};
        end
        default: ;
      endcase
    end
  end

  assign ld_ack       = r_ld_ack;
  assign cp_valid     = r_cp_valid;
  assign busy         = r_busy;
  assign mem_write_en = r_mem_we;
  assign mem_address  = r_mem_addr;
  assign mem_data1    = r_mem_d1;
  assign mem_data2    = r_mem_d2;
  assign mem_data3    = r_mem_d3;
  assign mem_data4    = r_mem_d4;
  assign cp_q1        = r_cp_q1;
  assign cp_q2        = r_cp_q2;
  assign cp_q3        = r_cp_q3;
  assign cp_q4        = r_cp_q4;

endmodule

// File: tb/tb_dmem_access_sched.sv
// tb/tb_dmem_access_sched.sv - directed self-checking bench for dmem_access_sched
module tb_dmem_access_sched;

  logic        clk;
  logic        rst_n;
  logic        ld_req, cp_req;
  logic [15:0] ld_addr, cp_addr;
  logic [15:0] ld_data1, ld_data2, ld_data3, ld_data4;
  logic        ld_ack, cp_valid, busy, mem_write_en;
  logic [15:0] cp_q1, cp_q2, cp_q3, cp_q4;
  logic [15:0] mem_address;
  logic [15:0] mem_data1, mem_data2, mem_data3, mem_data4;
  logic [15:0] mem_q1, mem_q2, mem_q3, mem_q4;

  int tests = 0;
  int fails = 0;
  int ld_cnt = 0;
  int cp_cnt = 0;
  logic prev_busy = 1'b0;
  logic grant_log[$];

  // Memory model: lane k returns 16'h00Ak xor address.
  assign mem_q1 = 16'h00A1 ^ mem_address;
  assign mem_q2 = 16'h00A2 ^ mem_address;
  assign mem_q3 = 16'h00A3 ^ mem_address;
  assign mem_q4 = 16'h00A4 ^ mem_address;

  dmem_access_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_data1     (ld_data1),
    .ld_data2     (ld_data2),
    .ld_data3     (ld_data3),
    .ld_data4     (ld_data4),
    .ld_ack       (ld_ack),
    .cp_req       (cp_req),
    .cp_addr      (cp_addr),
    .cp_valid     (cp_valid),
    .cp_q1        (cp_q1),
    .cp_q2        (cp_q2),
    .cp_q3        (cp_q3),
    .cp_q4        (cp_q4),
    .mem_address  (mem_address),
    .mem_write_en (mem_write_en),
    .mem_data1    (mem_data1),
    .mem_data2    (mem_data2),
    .mem_data3    (mem_data3),
    .mem_data4    (mem_data4),
    .mem_q1       (mem_q1),
    .mem_q2       (mem_q2),
    .mem_q3       (mem_q3),
    .mem_q4       (mem_q4),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ld_ack) ld_cnt++;
      if (cp_valid) cp_cnt++;
      if (busy && !prev_busy) grant_log.push_back(mem_write_en);
    end
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int ld0, cp0, g0;

  initial begin
    rst_n = 1'b0;
    ld_req = 1'b1; cp_req = 1'b1;
    ld_addr = 16'h0010; cp_addr = 16'h0000;
    ld_data1 = 16'd1; ld_data2 = 16'd2; ld_data3 = 16'd3; ld_data4 = 16'd4;
    repeat (3) tick();
    chk("rst_we",    32'(mem_write_en), 32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_addr",  32'(mem_address),  32'd0);
    chk("rst_ack",   32'(ld_ack),       32'd0);
    chk("rst_valid", 32'(cp_valid),     32'd0);
    chk("rst_q1",    32'(cp_q1),        32'd0);
    chk("rst_d1",    32'(mem_data1),    32'd0);

    // single write, loader wins the first conflict after reset
    rst_n = 1'b1;
    tick();
    cp_req = 1'b0;
    chk("wr_grant_we", 32'(mem_write_en), 32'd1);
    chk("wr_addr",     32'(mem_address),  32'h0010);
    chk("wr_d4",       32'(mem_data4),    32'd4);
    chk("wr_busy",     32'(busy),         32'd1);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk("wr_we_held", 32'(mem_write_en), 32'd1);
    end
    tick();
    chk("wr_we_drop",  32'(mem_write_en), 32'd0);
    chk("wr_ack_early",32'(ld_ack),       32'd0);
    tick();
    chk("wr_ack",      32'(ld_ack),       32'd1);
    chk("wr_no_valid", 32'(cp_valid),     32'd0);
    ld_req = 1'b0;
    tick();
    chk("wr_ack_pulse",32'(ld_ack),       32'd0);
    chk("wr_idle",     32'(busy),         32'd0);

    // held loader request after its ack must not be re-granted
    ld_addr = 16'h0040;
    ld_req = 1'b1;
    repeat (8) tick();
    chk("hold_ack",    32'(ld_ack),       32'd1);
    tick();
    chk("hold_no_regrant", 32'(busy),     32'd0);
    chk("hold_we",     32'(mem_write_en), 32'd0);
    ld_req = 1'b0;
    tick();
    chk("hold_idle",   32'(busy),         32'd0);

    // single read
    cp_addr = 16'h0000;
    cp_req = 1'b1;
    tick();
    chk("rd_we",       32'(mem_write_en), 32'd0);
    chk("rd_busy",     32'(busy),         32'd1);
    repeat (6) tick();
    chk("rd_valid_early", 32'(cp_valid),  32'd0);
    tick();
    chk("rd_valid",    32'(cp_valid),     32'd1);
    chk("rd_q1",       32'(cp_q1),        32'h00A1);
    chk("rd_q2",       32'(cp_q2),        32'h00A2);
    chk("rd_q3",       32'(cp_q3),        32'h00A3);
    chk("rd_q4",       32'(cp_q4),        32'h00A4);
    cp_req = 1'b0;
    tick();
    chk("rd_valid_pulse", 32'(cp_valid),  32'd0);
    chk("rd_q2_hold",  32'(cp_q2),        32'h00A2);

    // address change while the access is in flight
    cp_addr = 16'h0020;
    cp_req = 1'b1;
    tick();
    chk("mid_addr",    32'(mem_address),  32'h0020);
    cp_addr = 16'h0030;
    repeat (3) tick();
    chk("mid_addr_held", 32'(mem_address), 32'h0020);
    repeat (4) tick();
    chk("mid_valid",   32'(cp_valid),     32'd1);
    chk("mid_q1",      32'(cp_q1),        32'h0081);
    cp_req = 1'b0;
    tick();

    // contention: both held for four transactions
    ld_addr = 16'h0060;
    cp_addr = 16'h0070;
    ld0 = ld_cnt; cp0 = cp_cnt; g0 = grant_log.size();
    ld_req = 1'b1; cp_req = 1'b1;
    repeat (32) tick();
    ld_req = 1'b0; cp_req = 1'b0;
    repeat (2) tick();
    chk("ct_ld_acks",  32'(ld_cnt - ld0), 32'd2);
    chk("ct_cp_valids",32'(cp_cnt - cp0), 32'd2);
    chk("ct_grants",   32'(grant_log.size() - g0), 32'd4);
    if (grant_log.size() - g0 == 4) begin
      chk("ct_g0_ld",  32'(grant_log[g0]),   32'd1);
      chk("ct_g1_cp",  32'(grant_log[g0+1]), 32'd0);
      chk("ct_g2_ld",  32'(grant_log[g0+2]), 32'd1);
      chk("ct_g3_cp",  32'(grant_log[g0+3]), 32'd0);
    end
    chk("ct_idle",     32'(busy),         32'd0);

    // reset during an access
    ld_addr = 16'h0050;
    ld_req = 1'b1;
    tick();
    repeat (3) tick();
    chk("ab_we_before", 32'(mem_write_en), 32'd1);
    ld0 = ld_cnt;
    rst_n = 1'b0;
    #1;
    chk("ab_we",       32'(mem_write_en), 32'd0);
    chk("ab_busy",     32'(busy),         32'd0);
    chk("ab_addr",     32'(mem_address),  32'd0);
    ld_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("ab_no_ack",   32'(ld_cnt - ld0), 32'd0);
    chk("ab_idle",     32'(busy),         32'd0);
    chk("ab_q1_clr",   32'(cp_q1),        32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
